div_signed_frontend: RTL and testbench
======================================

Name: div_signed_frontend

Overview:
- Signed front-end and back-end wrapper around the unsigned pipelined divider.
- Accepts signed numerator/denominator pairs on a valid/ready interface and converts them to magnitudes.
- Paces requests so a new dv never hits the divider's busy first pipe.
- Tracks each request's sign and divide-by-zero flag in an in-order tag FIFO, then re-applies sign and saturation to the returned unsigned quotient. Sits between the DSP requester and the divider instance.

Parameters:
XDW, 16, numerator and quotient width in bits (signed at this block's ports)
YDW, 16, divider denominator width; the signed denominator port is YDW-1 bits
ISSUE_GAP, 16, minimum cycles between divider dv pulses; integrator sets it to the divider's XDW/GRAIN/PIPE
TAG_DEPTH, 4, tag FIFO depth and maximum outstanding requests (power of 2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
s_x_i  in  XDW  signed numerator
s_y_i  in  YDW-1  signed denominator
s_valid_i  in  1  request valid
s_ready_o  out  1  request accepted when s_valid_i and s_ready_o are both high
div_x_o  out  XDW  |x| to the divider x_i
div_y_o  out  YDW  |y| zero-extended, to the divider y_i
div_dv_o  out  1  one-cycle pulse to the divider dv_i
div_q_i  in  XDW  unsigned quotient from the divider q_o
div_dv_i  in  1  divider dv_o
m_q_o  out  XDW  signed quotient
m_valid_o  out  1  one-cycle result pulse; no backpressure
m_flags_o  out  2  bit0 = divide-by-zero, bit1 = overflow saturation; valid with m_valid_o
err_o  out  1  sticky: divider result arrived with the tag FIFO empty

Behaviour:
- Reset values: every output 0; gap counter 0; FIFO empty; err_o 0. The divider must share rst_i.
- Reset mid-operation clears all state. In-flight results are discarded and no m_valid_o follows reset.
- s_ready_o = (gap_cnt == 0) && (fifo_count < TAG_DEPTH). It is combinational from registers only and never depends on s_valid_i.
- Accept cycle, registered for the next cycle:
  - div_x_o = |s_x_i| as XDW-bit unsigned; -2^(XDW-1) maps to 2^(XDW-1).
  - div_y_o = {1'b0, |s_y_i|}. Magnitude ≤ 2^(YDW-2), which keeps it inside the divider's operating range.
  - div_dv_o = 1 for exactly one cycle.
  - gap_cnt loads ISSUE_GAP-1.
  - A tag {neg = sx^sy, dz = (s_y_i == 0), xneg = sx} is pushed.
- gap_cnt decrements each cycle while nonzero and saturates at 0, giving accept spacing ≥ ISSUE_GAP cycles.
- div_x_o and div_y_o hold their value between issues.
- Divide-by-zero requests are still issued to the divider, which preserves ordering. The result is replaced at the output.
- On div_dv_i, the head tag pops and the next cycle produces m_valid_o = 1:
  - dz: m_q_o = xneg ? -2^(XDW-1) : 2^(XDW-1)-1; flags = 01.
  - !neg and div_q_i > 2^(XDW-1)-1: m_q_o = 2^(XDW-1)-1; flags = 10. Only x = -2^(XDW-1), y = -1 produces this.
  - neg: m_q_o = -div_q_i, two's complement in XDW bits. div_q_i ≤ 2^(XDW-1), so it always fits.
  - otherwise: m_q_o = div_q_i; flags = 00.
- Rounding is truncation toward zero, with the remainder discarded.
- A push and a pop in the same cycle are both performed and fifo_count is unchanged.
- If div_dv_i arrives with the FIFO empty and no same-cycle push: no pop, no m_valid_o, err_o is set until reset. If a push happens that same cycle, it is not paired with the stray result.
- Latency from accept to m_valid_o = 1 + divider latency + 1. With GRAIN=1, PIPE=1, XDW=16 this is 1 + 18 + 1 = 20 cycles.
- Sustained throughput is one request per ISSUE_GAP cycles.

Test Plan:
- Basic signs: (100,7), (-100,7), (100,-7), (-100,-7) → 14, -14, -14, 14; flags 00; same order as issued.
- Overflow corner: x = -32768, y = -1 → m_q_o = 32767, flags = 10. Then x = -32768, y = 1 → -32768, flags = 00.
- Divide-by-zero: (5,0) → 32767, flags 01. (-5,0) → -32768, flags 01. (0,0) → 32767, flags 01.
- Pacing: s_valid_i held high with 8 distinct pairs:
  - Accepts occur exactly 16 cycles apart.
  - s_ready_o drops for 15 cycles after each accept.
  - All 8 results are correct and in order.
  - fifo_count never exceeds TAG_DEPTH.
- Backpressure from depth: a divider model stalling results with TAG_DEPTH=4 → after 4 accepts s_ready_o stays 0 until the first result pops. Push and pop in the same cycle keep the count at 4.
- Reset mid-flight: assert rst_i for 1 cycle, 5 cycles after an accept → no m_valid_o afterwards, s_ready_o = 1 the cycle after reset, err_o = 0. An injected stray div_dv_i with the FIFO empty → err_o = 1 and it stays high.

Source files
------------

// File: rtl/div_signed_frontend.sv
// Signed wrapper for the unsigned pipelined divider: takes |x| and |y|, paces dv pulses, keeps per-request sign/zero tags in order.
// Latency is 1 + divider latency + 1. Requests stall on the issue gap or a full tag FIFO; results cannot be backpressured.
module div_signed_frontend #(
  parameter int XDW       = 16,
  parameter int YDW       = 16,
  parameter int ISSUE_GAP = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [XDW-1:0] s_x_i,
  input  logic [YDW-2:0] s_y_i,
  input  logic           s_valid_i,
  output logic           s_ready_o,
  output logic [XDW-1:0] div_x_o,
  output logic [YDW-1:0] div_y_o,
  output logic           div_dv_o,
  input  logic [XDW-1:0] div_q_i,
  input  logic           div_dv_i,
  output logic [XDW-1:0] m_q_o,
  output logic           m_valid_o,
  output logic [1:0]     m_flags_o,
  output logic           err_o
);

  localparam int AW = $clog2(TAG_DEPTH);
  localparam int GW = $clog2(ISSUE_GAP + 1);
  localparam logic [XDW-1:0] Q_MAX    = {1'b0, {(XDW-1){1'b1}}};
  localparam logic [XDW-1:0] Q_MIN    = {1'b1, {(XDW-1){1'b0}}};
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(TAG_DEPTH);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [GW-1:0]  GAP_LOAD = GW'(ISSUE_GAP - 1);
  localparam logic [GW-1:0]  GAP_ONE  = GW'(1);

  typedef struct packed {
    logic xneg;
    logic dz;
    logic neg;
  } tag_t;

  logic [GW-1:0]  gap_cnt;
  logic [AW:0]    fifo_count;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  tag_t           tag_mem [TAG_DEPTH];
  tag_t           push_tag;
  tag_t           head_tag;
  logic           accept;
  logic           pop;
  logic [XDW-1:0] x_mag;
  logic [YDW-2:0] y_mag;

  assign s_ready_o = (gap_cnt == '0) && (fifo_count != CNT_FULL);
  assign accept    = s_valid_i && s_ready_o;
  // A result with no outstanding tag is never paired with a same-cycle push.
  assign pop       = div_dv_i && (fifo_count != '0);

  assign x_mag = s_x_i[XDW-1] ? -s_x_i : s_x_i;
  assign y_mag = s_y_i[YDW-2] ? -s_y_i : s_y_i;

  assign push_tag.xneg = s_x_i[XDW-1];
  assign push_tag.dz   = (s_y_i == '0);
  assign push_tag.neg  = s_x_i[XDW-1] ^ s_y_i[YDW-2];
  assign head_tag      = tag_mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (accept) begin
      tag_mem[wr_ptr] <= push_tag;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gap_cnt    <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      div_x_o    <= '0;
      div_y_o    <= '0;
      div_dv_o   <= 1'b0;
      m_q_o      <= '0;
      m_valid_o  <= 1'b0;
      m_flags_o  <= '0;
      err_o      <= 1'b0;
    end else begin
      div_dv_o  <= accept;
      m_valid_o <= pop;

      if (accept) begin
        div_x_o <= x_mag;
        div_y_o <= {1'b0, y_mag};
        gap_cnt <= GAP_LOAD;
        wr_ptr  <= wr_ptr + PTR_ONE;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_ONE;
      end

      if (accept && !pop) begin
        fifo_count <= fifo_count + CNT_ONE;
      end else if (pop && !accept) begin
        fifo_count <= fifo_count - CNT_ONE;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        // Zero-divide results are discarded; only x = MIN, y = -1 can exceed MAX unsigned.
        if (head_tag.dz) begin
          m_q_o     <= head_tag.xneg ? Q_MIN : Q_MAX;
          m_flags_o <= 2'b01;
        end else if (!head_tag.neg && (div_q_i > Q_MAX)) begin
          m_q_o     <= Q_MAX;
          m_flags_o <= 2'b10;
        end else begin
          m_q_o     <= head_tag.neg ? -div_q_i : div_q_i;
          m_flags_o <= 2'b00;
        end
      end

      if (div_dv_i && (fifo_count == '0)) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_signed_frontend.sv
// Bench for div_signed_frontend: behavioural divider with optional stall, spec-level result model and per-cycle compare.
module tb_div_signed_frontend;

  localparam int GAP     = 16;
  localparam int DEPTH   = 4;
  localparam int DIV_LAT = 18;
  localparam int LAT     = 20;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] s_x_i;
  logic [14:0] s_y_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [15:0] div_x_o;
  logic [15:0] div_y_o;
  logic        div_dv_o;
  logic [15:0] div_q_i;
  logic        div_dv_i;
  logic [15:0] m_q_o;
  logic        m_valid_o;
  logic [1:0]  m_flags_o;
  logic        err_o;

  div_signed_frontend #(.XDW(16), .YDW(16), .ISSUE_GAP(GAP), .TAG_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .s_x_i(s_x_i), .s_y_i(s_y_i), .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o), .div_x_o(div_x_o), .div_y_o(div_y_o), .div_dv_o(div_dv_o),
    .div_q_i(div_q_i), .div_dv_i(div_dv_i), .m_q_o(m_q_o), .m_valid_o(m_valid_o),
    .m_flags_o(m_flags_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { int due; logic [15:0] q; } dres_t;
  typedef struct { logic [17:0] v; int acc; } exp_t;

  dres_t       dq[$];
  exp_t        exp_q[$];
  logic [17:0] got_q[$];
  int          acc_log[$];
  bit          stall, inject, lat_chk;
  int          outst = 0;
  int          last_acc = -1000;
  int          mv_cnt = 0;
  bit          mv_exp = 0;
  bit          err_exp = 0;

  int px[8] = '{1000, -1000, 32767, -32767, 7, -1, 30000, -32768};
  int py[8] = '{3, 3, 1, -16384, -16384, 1, -7, 16383};
  logic [17:0] bexp[4] = '{18'h0000e, 18'h0fff2, 18'h0fff2, 18'h0000e};
  logic [17:0] oexp[5] = '{18'h27fff, 18'h08000, 18'h17fff, 18'h18000, 18'h17fff};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result {flags, q} straight from signed integer arithmetic (truncation toward zero).
  function automatic logic [17:0] model(input int x, input int y);
    int r;
    logic [17:0] v;
    if (y == 0) begin
      v = (x < 0) ? 18'h18000 : 18'h17fff;
    end else begin
      r = x / y;
      if (r > 32767) v = 18'h27fff;
      else v = {2'b00, r[15:0]};
    end
    return v;
  endfunction

  // Unsigned divider stand-in: fixed latency, shares reset, can hold results back.
  initial begin
    dres_t r;
    div_dv_i = 1'b0;
    div_q_i  = '0;
    forever begin
      @(posedge clk_i); #2;
      div_dv_i = 1'b0;
      if (rst_i) begin
        dq.delete();
      end else begin
        if (div_dv_o) begin
          r.due = cyc + DIV_LAT;
          r.q   = (div_y_o == 16'd0) ? 16'hffff : 16'(div_x_o / div_y_o);
          dq.push_back(r);
        end
        if (inject) begin
          div_dv_i = 1'b1;
          div_q_i  = 16'h0123;
          inject   = 1'b0;
        end else if (!stall && dq.size() > 0 && dq[0].due <= cyc) begin
          r = dq.pop_front();
          div_dv_i = 1'b1;
          div_q_i  = r.q;
        end
      end
    end
  end

  // Compare process: every cycle checks ready, err and result against the model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        exp_q.delete();
        outst = 0; last_acc = -1000; mv_exp = 0; err_exp = 0;
      end else begin
        chk("s_ready", s_ready_o, ((cyc - last_acc) >= GAP) && (outst < DEPTH));
        chk("err", err_o, err_exp);
        chk("m_valid", m_valid_o, mv_exp);
        if (m_valid_o && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("m_q", m_q_o, e.v[15:0]);
          chk("m_flags", m_flags_o, e.v[17:16]);
          if (lat_chk) chk("latency", cyc - e.acc, LAT);
          got_q.push_back({m_flags_o, m_q_o});
        end
        if (m_valid_o) mv_cnt++;
        mv_exp = div_dv_i && (outst > 0);
        if (div_dv_i && outst == 0) err_exp = 1'b1;
        if (div_dv_i && outst > 0) outst--;
        if (s_valid_i && s_ready_o) begin
          e.v   = model(int'($signed(s_x_i)), int'($signed(s_y_i)));
          e.acc = cyc;
          exp_q.push_back(e);
          acc_log.push_back(cyc);
          outst++;
          last_acc = cyc;
        end
      end
    end
  end

  task automatic send(input int x, input int y, input bit hold);
    int n;
    n = 0;
    s_x_i = x[15:0];
    s_y_i = y[14:0];
    s_valid_i = 1'b1;
    @(negedge clk_i);
    while (!s_ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    chk("send_accept", n < 300, 1);
    @(posedge clk_i); #1;
    if (!hold) s_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || outst != 0) && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain", n < 400, 1);
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: run did not complete (errors so far %0d)", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, mv0;
    rst_i = 1'b1; s_valid_i = 1'b0; s_x_i = '0; s_y_i = '0;
    stall = 1'b0; inject = 1'b0; lat_chk = 1'b1;

    chk("model_100_7", model(100, 7), 18'h0000e);
    chk("model_m100_7", model(-100, 7), 18'h0fff2);
    chk("model_ovf", model(-32768, -1), 18'h27fff);
    chk("model_min_1", model(-32768, 1), 18'h08000);
    chk("model_dz_pos", model(5, 0), 18'h17fff);
    chk("model_dz_neg", model(-5, 0), 18'h18000);
    chk("model_trunc", model(30000, -7), 18'h0ef43);

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_s_ready", s_ready_o, 1);
    chk("rst_div_dv", div_dv_o, 0);
    chk("rst_div_x", div_x_o, 0);
    chk("rst_div_y", div_y_o, 0);
    chk("rst_m_valid", m_valid_o, 0);
    chk("rst_m_q", m_q_o, 0);
    chk("rst_m_flags", m_flags_o, 0);
    chk("rst_err", err_o, 0);
    @(posedge clk_i); #1;

    got_q.delete();
    send(100, 7, 0); send(-100, 7, 0); send(100, -7, 0); send(-100, -7, 0);
    wait_idle();
    chk("basic_count", got_q.size(), 4);
    if (got_q.size() == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("basic_res%0d", i), got_q[i], bexp[i]);

    got_q.delete();
    send(-32768, -1, 0); send(-32768, 1, 0); send(5, 0, 0); send(-5, 0, 0); send(0, 0, 0);
    chk("div_y_zero_issue", div_y_o, 0);
    wait_idle();
    chk("corner_count", got_q.size(), 5);
    if (got_q.size() == 5)
      for (int i = 0; i < 5; i++) chk($sformatf("corner_res%0d", i), got_q[i], oexp[i]);

    base = acc_log.size();
    got_q.delete();
    for (int i = 0; i < 8; i++) send(px[i], py[i], i < 7);
    wait_idle();
    chk("pace_count", acc_log.size() - base, 8);
    chk("pace_results", got_q.size(), 8);
    if (acc_log.size() == base + 8)
      for (int i = 0; i < 7; i++)
        chk($sformatf("pace_gap%0d", i), acc_log[base+i+1] - acc_log[base+i], GAP);

    lat_chk = 1'b0;
    stall = 1'b1;
    base = acc_log.size();
    for (int i = 0; i < 4; i++) send(200 + i, -3, 1);
    s_x_i = 16'd999; s_y_i = 15'd9;
    repeat (40) @(negedge clk_i);
    chk("depth_accepts", acc_log.size() - base, 4);
    chk("depth_ready_low", s_ready_o, 0);
    @(posedge clk_i); #1;
    stall = 1'b0;
    send(999, 9, 1);
    send(-999, 9, 0);
    wait_idle();
    chk("depth_total", acc_log.size() - base, 6);
    lat_chk = 1'b1;

    send(1000, 10, 0);
    repeat (4) begin @(posedge clk_i); #1; end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    mv0 = mv_cnt;
    @(negedge clk_i);
    chk("post_rst_ready", s_ready_o, 1);
    chk("post_rst_err", err_o, 0);
    chk("post_rst_valid", m_valid_o, 0);
    repeat (40) @(negedge clk_i);
    chk("post_rst_no_result", mv_cnt - mv0, 0);

    @(posedge clk_i); #1;
    inject = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("stray_err_set", err_o, 1);
    repeat (20) @(negedge clk_i);
    chk("stray_err_sticky", err_o, 1);
    chk("stray_no_result", mv_cnt - mv0, 0);
    chk("final_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
